alu_div_iter: RTL

ALU_DIV_ITER -- requirements
Module: alu_div_iter

---
 rtl/alu_div_iter_pkg.sv | 12 +
 rtl/alu_div_sign_fix.sv | 23 ++
 rtl/alu_div_iter.sv | 100 ++++++++++
 3 files changed

// File: rtl/alu_div_iter_pkg.sv
// alu_div_iter_pkg: shared XLEN configuration and divider FSM state encodings
`ifndef XLEN
`define XLEN 64
`endif
package alu_div_iter_pkg;
  localparam int XLEN = `XLEN;
  localparam int CNT_W = $clog2(XLEN);
  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_CALC = 2'd1;
  localparam logic [1:0] DIV_FIX = 2'd2;
  localparam logic [1:0] DIV_DONE = 2'd3;
endpackage

// File: rtl/alu_div_sign_fix.sv
// alu_div_sign_fix: operand absolute values and result sign negation
module alu_div_sign_fix
  import alu_div_iter_pkg::*;
(
  input  logic            sgn,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [XLEN-1:0] q_raw,
  input  logic [XLEN-1:0] r_raw,
  input  logic            q_neg,
  input  logic            r_neg,
  output logic [XLEN-1:0] a_abs,
  output logic [XLEN-1:0] b_abs,
  output logic [XLEN-1:0] q_fix,
  output logic [XLEN-1:0] r_fix
);
  always_comb begin
    a_abs = (sgn && a[XLEN-1]) ? -a : a;
    b_abs = (sgn && b[XLEN-1]) ? -b : b;
    q_fix = q_neg ? -q_raw : q_raw;
    r_fix = r_neg ? -r_raw : r_raw;
  end
endmodule

// File: rtl/alu_div_iter.sv
// alu_div_iter: iterative restoring divider, one quotient bit per cycle
// ALU_DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow skip the iteration
module alu_div_iter
  import alu_div_iter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic               div_signed_i,
  input  logic [`XLEN-1:0]   rs1_data_i,
  input  logic [`XLEN-1:0]   rs2_data_i,
  input  logic               flush_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [`XLEN-1:0]   quotient_o,
  output logic [`XLEN-1:0]   remainder_o
);
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  quo, rem, dvs;
  logic             q_neg, r_neg;
  logic [XLEN:0]    rem_sh, diff;
  logic [XLEN-1:0]  a_abs, b_abs, q_fix, r_fix;
  logic             ge;
`ifdef ALU_DIV_FAST_SPECIAL_EN
  logic dz, ovf;
  assign dz = rs2_data_i == '0;
  assign ovf = div_signed_i && rs1_data_i == {1'b1, {(XLEN-1){1'b0}}} && &rs2_data_i;
`endif
  alu_div_sign_fix u_fix (
    .sgn   (div_signed_i),
    .a     (rs1_data_i),
    .b     (rs2_data_i),
    .q_raw (quo),
    .r_raw (rem),
    .q_neg (q_neg),
    .r_neg (r_neg),
    .a_abs (a_abs),
    .b_abs (b_abs),
    .q_fix (q_fix),
    .r_fix (r_fix)
  );
  always_comb begin
    rem_sh = {rem, quo[XLEN-1]};
    diff = rem_sh - {1'b0, dvs};
    ge = !diff[XLEN];
  end
  assign ready_o = state == DIV_IDLE;
  assign valid_o = state == DIV_DONE;
  assign quotient_o = quo;
  assign remainder_o = rem;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= DIV_IDLE;
      cnt <= '0;
      quo <= '0;
      rem <= '0;
      dvs <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (flush_i) begin
      state <= DIV_IDLE;
    end else begin
      case (state)
        DIV_IDLE: if (valid_i) begin
`ifdef ALU_DIV_FAST_SPECIAL_EN
          if (dz || ovf) begin
            state <= DIV_DONE;
            quo <= dz ? '1 : rs1_data_i;
            rem <= dz ? rs1_data_i : '0;
          end else
`endif
          begin
            state <= DIV_CALC;
            cnt <= '0;
            quo <= a_abs;
            rem <= '0;
            dvs <= b_abs;
            // a zero divisor keeps the all-ones quotient unsigned-looking
            q_neg <= div_signed_i && (rs1_data_i[XLEN-1] ^ rs2_data_i[XLEN-1]) && |rs2_data_i;
            r_neg <= div_signed_i && rs1_data_i[XLEN-1];
          end
        end
        DIV_CALC: begin
          quo <= {quo[XLEN-2:0], ge};
          rem <= ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(XLEN-1)) state <= DIV_FIX;
        end
        DIV_FIX: begin
          quo <= q_fix;
          rem <= r_fix;
          state <= DIV_DONE;
        end
        default: if (ready_i) state <= DIV_IDLE;
      endcase
    end
  end
endmodule
